// File: rtl/integral_image_rect_sum.sv
// ============================================================================
// Module   : integral_image_rect_sum
// Summary  : Fetches up to four integral-image corners over BRAM port B and
//            returns the rectangle sum D - B - C + A. Optional request bounds
//            checking is enabled with the RECT_BOUNDS_CHECK_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module integral_image_rect_sum #(
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 20,
    parameter int COORD_W    = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk_vga,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x0,
    input  logic [COORD_W-1:0] req_y0,
    input  logic [COORD_W-1:0] req_w,
    input  logic [COORD_W-1:0] req_h,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0]  ii_rddata,
    output logic               res_valid,
    output logic [DATA_W-1:0]  res_sum,
    output logic               res_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] c_IMG_W = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] c_ONE   = ADDR_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [COORD_W-1:0] r_x0, r_y0, r_w, r_h;
    logic               r_reject;
    logic [1:0]         r_slot;
    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [3:0]         r_issue_tag;              // {valid, live, subtract, last}
    logic [3:0]         r_tag_pipe [RD_LATENCY];
    logic [DATA_W-1:0]  r_acc;
    logic               r_res_valid;
    logic [DATA_W-1:0]  r_res_sum;
    logic               r_res_err;

    logic               w_accept;
    logic               w_reject_in;
    logic [ADDR_W-1:0]  w_x0, w_y0, w_x1, w_y1, w_xm, w_ym;
    logic [ADDR_W-1:0]  w_slot_x, w_slot_y, w_slot_addr;
    logic               w_slot_live, w_slot_sub;
    logic [3:0]         w_tag_out;
    logic [DATA_W-1:0]  w_acc_next;
    logic               w_finish;

    assign req_ready = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept  = req_valid && req_ready;

`ifdef RECT_BOUNDS_CHECK_EN
    logic [COORD_W:0] w_x_end, w_y_end;
    assign w_x_end     = {1'b0, req_x0} + {1'b0, req_w};
    assign w_y_end     = {1'b0, req_y0} + {1'b0, req_h};
    assign w_reject_in = (req_w == '0) || (req_h == '0) ||
                         (w_x_end > (COORD_W+1)'(IMG_W)) ||
                         (w_y_end > (COORD_W+1)'(IMG_H));
`else
    assign w_reject_in = 1'b0;
`endif

    assign w_x0 = ADDR_W'(r_x0);
    assign w_y0 = ADDR_W'(r_y0);
    assign w_x1 = w_x0 + ADDR_W'(r_w) - c_ONE;
    assign w_y1 = w_y0 + ADDR_W'(r_h) - c_ONE;
    assign w_xm = w_x0 - c_ONE;
    assign w_ym = w_y0 - c_ONE;

    // Slot order D, B, C, A; corners left of column 0 or above row 0 read as zero.
    always_comb begin
        w_slot_x    = w_x1;
        w_slot_y    = w_y1;
        w_slot_live = 1'b1;
        w_slot_sub  = 1'b0;
        case (r_slot)
            2'd1: begin
                w_slot_y    = w_ym;
                w_slot_live = (r_y0 != '0);
                w_slot_sub  = 1'b1;
            end
            2'd2: begin
                w_slot_x    = w_xm;
                w_slot_live = (r_x0 != '0);
                w_slot_sub  = 1'b1;
            end
            2'd3: begin
                w_slot_x    = w_xm;
                w_slot_y    = w_ym;
                w_slot_live = (r_x0 != '0) && (r_y0 != '0);
            end
            default: ;
        endcase
    end

    assign w_slot_addr = w_slot_y * c_IMG_W + w_slot_x;
    assign w_tag_out   = r_tag_pipe[RD_LATENCY-1];

    always_comb begin
        w_acc_next = r_acc;
        if (w_tag_out[3] && w_tag_out[2]) begin
            w_acc_next = w_tag_out[1] ? (r_acc - ii_rddata) : (r_acc + ii_rddata);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ISSUE;
            S_ISSUE: if (r_reject || (r_slot == 2'd3)) w_state_next = S_DRAIN;
            S_DRAIN: if (r_reject || (w_tag_out[3] && w_tag_out[0])) w_state_next = S_DONE;
            S_DONE:  w_state_next = w_accept ? S_ISSUE : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_finish = (r_state == S_DRAIN) && (w_state_next == S_DONE);

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x0        <= '0;
            r_y0        <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_reject    <= 1'b0;
            r_slot      <= 2'd0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_issue_tag <= '0;
            for (int i = 0; i < RD_LATENCY; i++) r_tag_pipe[i] <= '0;
            r_acc       <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_x0     <= req_x0;
                r_y0     <= req_y0;
                r_w      <= req_w;
                r_h      <= req_h;
                r_reject <= w_reject_in;
                r_slot   <= 2'd0;
            end else if (r_state == S_ISSUE) begin
                r_slot <= r_slot + 2'd1;
            end

            if ((r_state == S_ISSUE) && !r_reject) begin
                r_rd_en     <= w_slot_live;
                r_rd_addr   <= w_slot_live ? w_slot_addr : '0;
                r_issue_tag <= {1'b1, w_slot_live, w_slot_sub, (r_slot == 2'd3)};
            end else begin
                r_rd_en     <= 1'b0;
                r_rd_addr   <= '0;
                r_issue_tag <= '0;
            end

            // Tag follows the read so it lines up with ii_rddata at the pipe end.
            r_tag_pipe[0] <= r_issue_tag;
            for (int i = 1; i < RD_LATENCY; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];

            r_res_valid <= w_finish;
            if (w_finish) begin
                r_res_sum <= r_reject ? '0 : w_acc_next;
                r_res_err <= r_reject;
                r_acc     <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_err   = r_res_err;

endmodule

`default_nettype wire

// File: tb/tb_integral_image_rect_sum.sv
// ============================================================================
// Module   : tb_integral_image_rect_sum
// Summary  : Directed scoreboard bench for integral_image_rect_sum with a
//            one-cycle-latency BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_integral_image_rect_sum;

    localparam int IMG_W      = 160;
    localparam int IMG_H      = 120;
    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 20;
    localparam int COORD_W    = 8;
    localparam int RD_LATENCY = 1;
    localparam longint c_MASK = (longint'(1) << DATA_W) - 1;

    logic               clk_vga = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [COORD_W-1:0] req_x0, req_y0, req_w, req_h;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  ii_rddata = '0;
    logic               res_valid;
    logic [DATA_W-1:0]  res_sum;
    logic               res_err;

    integral_image_rect_sum #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .COORD_W(COORD_W), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk_vga(clk_vga), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x0(req_x0), .req_y0(req_y0), .req_w(req_w), .req_h(req_h),
        .rd_en(rd_en), .rd_addr(rd_addr), .ii_rddata(ii_rddata),
        .res_valid(res_valid), .res_sum(res_sum), .res_err(res_err)
    );

    always #5 clk_vga = ~clk_vga;

    logic [DATA_W-1:0] mem [IMG_W*IMG_H];
    always @(posedge clk_vga) begin
        if (rd_en && (int'(rd_addr) < IMG_W*IMG_H)) ii_rddata <= mem[rd_addr];
    end

    int cyc = 0;
    always @(posedge clk_vga) cyc <= cyc + 1;

    typedef struct {
        longint sum;
        bit     err;
        int     due;
    } res_t;

    res_t res_q[$];
    int   addr_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pixel value pix everywhere: ii(x,y) = pix*(x+1)*(y+1), stored modulo 2^DATA_W.
    task automatic load_image(input int pix);
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                mem[y*IMG_W + x] = DATA_W'((longint'(pix) * (x+1) * (y+1)) & c_MASK);
    endtask

    task automatic send(input int x0, input int y0, input int w, input int h,
                        input int pix, input bit reject, output int acc_cyc);
        res_t e;
        bit   got;
        req_x0    = COORD_W'(x0);
        req_y0    = COORD_W'(y0);
        req_w     = COORD_W'(w);
        req_h     = COORD_W'(h);
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (req_ready) got = 1'b1;
            else @(negedge clk_vga);
        end
        if (!got) check("accept_timeout", 0, 1);
        @(posedge clk_vga);
        @(negedge clk_vga);
        req_valid = 1'b0;
        acc_cyc   = cyc;
        e.err = reject;
        e.sum = reject ? 0 : ((longint'(pix) * w * h) & c_MASK);
        e.due = acc_cyc + (reject ? 2 : RD_LATENCY + 5);
        res_q.push_back(e);
        if (!reject) begin
            addr_q.push_back((y0+h-1)*IMG_W + (x0+w-1));
            if (y0 > 0) addr_q.push_back((y0-1)*IMG_W + (x0+w-1));
            if (x0 > 0) addr_q.push_back((y0+h-1)*IMG_W + (x0-1));
            if (x0 > 0 && y0 > 0) addr_q.push_back((y0-1)*IMG_W + (x0-1));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((res_q.size() != 0 || addr_q.size() != 0) && n < 60) begin
            @(negedge clk_vga);
            n++;
        end
        if (res_q.size() != 0 || addr_q.size() != 0) begin
            check("result_timeout", res_q.size() + addr_q.size(), 0);
            res_q.delete();
            addr_q.delete();
        end
    endtask

    always @(negedge clk_vga) begin
        if (!rst) begin
            if (rd_en) begin
                if (addr_q.size() == 0) check("rd_en_unexpected", 1, 0);
                else check("rd_addr", longint'(rd_addr), longint'(addr_q.pop_front()));
            end else begin
                check("rd_addr_idle", longint'(rd_addr), 0);
            end
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    check("res_valid_unexpected", 1, 0);
                end else begin
                    res_t e;
                    e = res_q.pop_front();
                    check("res_sum", longint'(res_sum), e.sum);
                    check("res_err", longint'(res_err), longint'(e.err));
                    check("res_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        int a1, a2;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_x0    = '0;
        req_y0    = '0;
        req_w     = '0;
        req_h     = '0;
        repeat (2) @(negedge clk_vga);
        check("rst_req_ready", req_ready, 1);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_sum", res_sum, 0);
        check("rst_res_err", res_err, 0);
        rst = 1'b0;
        @(negedge clk_vga);

        load_image(1);
        send(10, 5, 4, 3, 1, 1'b0, a1);    wait_idle();
        send(0, 0, 2, 2, 1, 1'b0, a1);     wait_idle();
        send(0, 0, 160, 120, 1, 1'b0, a1); wait_idle();
        send(3, 0, 2, 4, 1, 1'b0, a1);     wait_idle();
        send(0, 9, 5, 1, 1, 1'b0, a1);     wait_idle();

        load_image(255);
        send(0, 0, 160, 120, 255, 1'b0, a1); wait_idle();
        send(20, 20, 40, 40, 255, 1'b0, a1); wait_idle();

        // Second request is held while busy and taken right after the DONE cycle.
        send(5, 7, 10, 6, 255, 1'b0, a1);
        send(30, 40, 8, 9, 255, 1'b0, a2);
        check("b2b_accept_gap", a2 - a1, RD_LATENCY + 6);
        wait_idle();
        repeat (3) @(negedge clk_vga);
        check("res_sum_hold", res_sum, (255 * 72) & c_MASK);
        check("res_valid_low", res_valid, 0);

        send(5, 5, 3, 3, 255, 1'b0, a1);
        repeat (RD_LATENCY + 4) @(negedge clk_vga);
        rst = 1'b1;
        #1;
        check("abort_req_ready", req_ready, 1);
        check("abort_rd_en", rd_en, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_res_sum", res_sum, 0);
        res_q.delete();
        addr_q.delete();
        @(negedge clk_vga);
        rst = 1'b0;
        repeat (10) @(negedge clk_vga);

        load_image(1);
        send(3, 3, 1, 1, 1, 1'b0, a1); wait_idle();

`ifdef RECT_BOUNDS_CHECK_EN
        send(150, 0, 20, 1, 1, 1'b1, a1); wait_idle();
        send(0, 0, 0, 5, 1, 1'b1, a1);    wait_idle();
        send(0, 0, 5, 0, 1, 1'b1, a1);    wait_idle();
        send(150, 110, 10, 10, 1, 1'b0, a1); wait_idle();
`endif

        repeat (3) @(negedge clk_vga);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
